// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port 64-bit memory between instruction
// fetch, data load/store and an external loader. One access is in flight at
// a time. Byte addresses, sizes and lanes are converted to word accesses.
// Read data is captured after a fixed memory latency, and every access ends
// with a one-cycle acknowledge to the requester that owned it.
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int RD_LATENCY = 1,
  parameter int MAX_STARVE = 8
) (
  input  logic              clock,
  input  logic              reset,
  // instruction fetch
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_ack,
  output logic [31:0]       inst_rddata,
  // data load/store
  input  logic              data_req,
  input  logic [1:0]        data_cmd,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [2:0]        data_size,
  input  logic [63:0]       data_wrdata,
  output logic              data_ack,
  output logic [63:0]       data_rddata,
  output logic              data_err,
  // external loader
  input  logic              ext_req,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [31:0]       ext_wrdata,
  output logic              ext_ack,
  // memory macro
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-4:0] mem_addr,
  output logic [63:0]       mem_wrdata,
  output logic [7:0]        mem_wrmask,
  input  logic [63:0]       mem_rddata
);

  localparam int            SW         = $clog2(MAX_STARVE + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);
  localparam logic [1:0]    LAT_INIT   = 2'(RD_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {OWN_INST, OWN_DATA, OWN_EXT} owner_t;

  // Byte-enable pattern for an access of 2**size bytes starting at lane off.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] base;
    case (size)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

  // Keeps the low 2**size bytes of a right-aligned word, zeroing the rest.
  function automatic logic [63:0] size_mask64(input logic [1:0] size);
    case (size)
      2'd0:    return 64'h0000_0000_0000_00FF;
      2'd1:    return 64'h0000_0000_0000_FFFF;
      2'd2:    return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // An access is refused when its size is illegal or it spills past lane 7.
  function automatic logic access_err(input logic [2:0] size, input logic [2:0] off);
    if (size[2]) return 1'b1;
    return ({1'b0, off} + (4'd1 << size[1:0])) > 4'd8;
  endfunction

  state_t        state;
  owner_t        lat_owner;
  logic          lat_read;
  logic [2:0]    lat_off;
  logic [1:0]    lat_size;
  logic          lat_hi;
  logic [1:0]    lat_cnt;
  logic          rr_last_inst;
  logic [SW-1:0] starve_cnt;

  logic          force_core;
  logic          grant_ext;
  logic          grant_data;
  logic          grant_inst;
  logic          data_is_wr;
  logic          data_bad;
  logic [2:0]    data_off;

  // Byte-offset bits of the word-aligned requesters carry no information.
  logic          unused_addr_bits;
  assign unused_addr_bits = ^{inst_addr[1:0], ext_addr[1:0]};

  // Arbitration: ext first unless a starved core requester must be forced through.
  always_comb begin
    data_off   = data_addr[2:0];
    data_is_wr = (data_cmd == 2'd1);
    data_bad   = access_err(data_size, data_off);
    force_core = (starve_cnt == STARVE_MAX) && (data_req || inst_req);
    grant_ext  = ext_req && !force_core;
    grant_data = !grant_ext && data_req && (!inst_req || rr_last_inst);
    grant_inst = !grant_ext && inst_req && !grant_data;
  end

  // Payload of the winner is captured in IDLE and used until the ack.
  always_ff @(posedge clock) begin
    if (state == IDLE) begin
      if (grant_ext) begin
        lat_owner <= OWN_EXT;
        lat_read  <= 1'b0;
      end else if (grant_data) begin
        lat_owner <= OWN_DATA;
        lat_read  <= !data_is_wr;
      end else begin
        lat_owner <= OWN_INST;
        lat_read  <= 1'b1;
      end
      lat_off  <= data_off;
      lat_size <= data_size[1:0];
      lat_hi   <= inst_addr[2];
    end
  end

  // Access sequencer: grant, strobe memory once, wait for read data, acknowledge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      lat_cnt      <= 2'd0;
      rr_last_inst <= 1'b1;
      starve_cnt   <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wrdata   <= '0;
      mem_wrmask   <= '0;
      inst_ack     <= 1'b0;
      inst_rddata  <= '0;
      data_ack     <= 1'b0;
      data_rddata  <= '0;
      data_err     <= 1'b0;
      ext_ack      <= 1'b0;
    end else begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wrdata  <= '0;
      mem_wrmask  <= '0;
      inst_ack    <= 1'b0;
      inst_rddata <= '0;
      data_ack    <= 1'b0;
      data_rddata <= '0;
      data_err    <= 1'b0;
      ext_ack     <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_ext) begin
            state      <= ISSUE;
            mem_req    <= 1'b1;
            mem_we     <= 1'b1;
            mem_addr   <= ext_addr[ADDR_W-1:3];
            mem_wrdata <= {ext_wrdata, ext_wrdata};
            mem_wrmask <= ext_addr[2] ? 8'hF0 : 8'h0F;
            if ((data_req || inst_req) && (starve_cnt != STARVE_MAX))
              starve_cnt <= starve_cnt + 1'b1;
          end else if (grant_data) begin
            rr_last_inst <= 1'b0;
            starve_cnt   <= '0;
            if (data_bad) begin
              state    <= DONE;
              data_ack <= 1'b1;
              data_err <= 1'b1;
            end else begin
              state    <= ISSUE;
              mem_req  <= 1'b1;
              mem_we   <= data_is_wr;
              mem_addr <= data_addr[ADDR_W-1:3];
              if (data_is_wr) begin
                mem_wrdata <= data_wrdata << {data_off, 3'b000};
                mem_wrmask <= lane_mask(data_size[1:0], data_off);
              end
            end
          end else if (grant_inst) begin
            rr_last_inst <= 1'b1;
            starve_cnt   <= '0;
            state        <= ISSUE;
            mem_req      <= 1'b1;
            mem_addr     <= inst_addr[ADDR_W-1:3];
          end
        end
        ISSUE: begin
          if (lat_read) begin
            state   <= WAIT;
            lat_cnt <= LAT_INIT;
          end else begin
            state <= DONE;
            if (lat_owner == OWN_EXT) ext_ack  <= 1'b1;
            else                      data_ack <= 1'b1;
          end
        end
        WAIT: begin
          if (lat_cnt == 2'd0) begin
            state <= DONE;
            if (lat_owner == OWN_INST) begin
              inst_ack    <= 1'b1;
              inst_rddata <= lat_hi ? mem_rddata[63:32] : mem_rddata[31:0];
            end else begin
              data_ack    <= 1'b1;
              data_rddata <= (mem_rddata >> {lat_off, 3'b000}) & size_mask64(lat_size);
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a latency-1 instance with a byte-masked memory
// model for the main traffic and a latency-3 instance for reset during WAIT.
// Expected acks are queued when requests are driven and consumed by monitors.
module tb_mem_port_arbiter;

  typedef struct {
    int          who;     // 0 inst, 1 data, 2 ext
    logic [63:0] rd;
    logic        err;
    logic        chk_rd;
    int          cyc;     // expected ack cycle, -1 = not checked
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        inst_req;
  logic [15:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rddata;
  logic        data_req;
  logic [1:0]  data_cmd;
  logic [15:0] data_addr;
  logic [2:0]  data_size;
  logic [63:0] data_wrdata;
  logic        data_ack;
  logic [63:0] data_rddata;
  logic        data_err;
  logic        ext_req;
  logic [15:0] ext_addr;
  logic [31:0] ext_wrdata;
  logic        ext_ack;
  logic        mem_req;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [63:0] mem_wrdata;
  logic [7:0]  mem_wrmask;
  logic [63:0] mem_rddata;

  logic        inst_req_b;
  logic [15:0] inst_addr_b;
  logic        inst_ack_b;
  logic [31:0] inst_rddata_b;
  logic        mem_req_b;
  logic [12:0] mem_addr_b;
  logic [63:0] mem_rddata_b;
  logic        unused_b_data_ack;
  logic [63:0] unused_b_data_rddata;
  logic        unused_b_data_err;
  logic        unused_b_ext_ack;
  logic        unused_b_mem_we;
  logic [63:0] unused_b_mem_wrdata;
  logic [7:0]  unused_b_mem_wrmask;

  mem_port_arbiter #(.ADDR_W(16), .RD_LATENCY(1), .MAX_STARVE(8)) dut (
    .clock(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack), .inst_rddata(inst_rddata),
    .data_req(data_req), .data_cmd(data_cmd), .data_addr(data_addr), .data_size(data_size),
    .data_wrdata(data_wrdata), .data_ack(data_ack), .data_rddata(data_rddata), .data_err(data_err),
    .ext_req(ext_req), .ext_addr(ext_addr), .ext_wrdata(ext_wrdata), .ext_ack(ext_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wrdata(mem_wrdata),
    .mem_wrmask(mem_wrmask), .mem_rddata(mem_rddata)
  );

  mem_port_arbiter #(.ADDR_W(16), .RD_LATENCY(3), .MAX_STARVE(8)) u_lat3 (
    .clock(clk), .reset(reset),
    .inst_req(inst_req_b), .inst_addr(inst_addr_b), .inst_ack(inst_ack_b), .inst_rddata(inst_rddata_b),
    .data_req(1'b0), .data_cmd(2'b00), .data_addr(16'h0000), .data_size(3'b000),
    .data_wrdata(64'h0), .data_ack(unused_b_data_ack), .data_rddata(unused_b_data_rddata),
    .data_err(unused_b_data_err),
    .ext_req(1'b0), .ext_addr(16'h0000), .ext_wrdata(32'h0), .ext_ack(unused_b_ext_ack),
    .mem_req(mem_req_b), .mem_we(unused_b_mem_we), .mem_addr(mem_addr_b),
    .mem_wrdata(unused_b_mem_wrdata), .mem_wrmask(unused_b_mem_wrmask), .mem_rddata(mem_rddata_b)
  );

  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  int   n_acks = 0;
  int   n_acks_b = 0;
  int   mreq_cnt = 0;
  exp_t exp_q[$];
  exp_t exp_qb[$];

  logic        last_we;
  logic [12:0] last_addr;
  logic [63:0] last_wd;
  logic [7:0]  last_mask;
  int          last_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Memory contents before any write.
  function automatic logic [63:0] pat_a(input int i);
    if (i == 2) return 64'h8877_6655_4433_2211;
    return {32'hAA00_0000 + 32'(i), 32'h5500_0000 + 32'(i)};
  endfunction

  function automatic logic [63:0] pat_b(input logic [12:0] w);
    return {16'hB0B0, 3'b000, w, 16'hC0C0, 3'b000, w};
  endfunction

  // Latency-1 memory with byte write enables.
  logic [63:0] mem_a [0:8191];
  logic [63:0] rd_pipe_a;
  assign mem_rddata = rd_pipe_a;

  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 8192; i++) mem_a[i] <= pat_a(i);
    end else if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 8; b++)
          if (mem_wrmask[b]) mem_a[mem_addr][8*b +: 8] <= mem_wrdata[8*b +: 8];
      end else begin
        rd_pipe_a <= mem_a[mem_addr];
      end
    end
  end

  // Latency-3 read-only memory.
  logic [63:0] pb [0:2];
  assign mem_rddata_b = pb[2];
  always @(posedge clk) begin
    pb[0] <= mem_req_b ? pat_b(mem_addr_b) : 64'h0;
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end

  always @(negedge clk) begin : mon_a
    exp_t e;
    int   who;
    if (inst_ack || data_ack || ext_ack) begin
      n_acks++;
      who = inst_ack ? 0 : (data_ack ? 1 : 2);
      check("ack_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("ack_requester", 64'(who), 64'(e.who));
        check("single_ack", 64'(inst_ack) + 64'(data_ack) + 64'(ext_ack), 64'd1);
        if (e.chk_rd && who == 0) check("inst_rddata", {32'b0, inst_rddata}, e.rd);
        if (e.chk_rd && who == 1) check("data_rddata", data_rddata, e.rd);
        if (who == 1) check("data_err", 64'(data_err), 64'(e.err));
        if (e.cyc >= 0) check("ack_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (mem_req) begin
      mreq_cnt++;
      last_we   = mem_we;
      last_addr = mem_addr;
      last_wd   = mem_wrdata;
      last_mask = mem_wrmask;
      last_cyc  = cyc;
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (inst_ack_b) begin
      n_acks_b++;
      check("lat3_ack_expected", 64'(exp_qb.size() != 0), 64'd1);
      if (exp_qb.size() != 0) begin
        e = exp_qb.pop_front();
        check("lat3_inst_rddata", {32'b0, inst_rddata_b}, e.rd);
        check("lat3_ack_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic wait_acks(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (n_acks < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check({tag, "_completed"}, 64'(n_acks >= target), 64'd1);
  endtask

  task automatic do_data(input logic [1:0] cmd, input logic [15:0] addr, input logic [2:0] size,
                         input logic [63:0] wd, input logic [63:0] erd, input logic eerr,
                         input logic chkrd, input int lat, output int t);
    exp_t e;
    @(negedge clk);
    data_req = 1'b1; data_cmd = cmd; data_addr = addr; data_size = size; data_wrdata = wd;
    t = cyc;
    e.who = 1; e.rd = erd; e.err = eerr; e.chk_rd = chkrd; e.cyc = cyc + lat;
    exp_q.push_back(e);
    wait_acks(n_acks + 1, 30, "data_op");
    data_req = 1'b0;
  endtask

  task automatic do_inst(input logic [15:0] addr, input logic [63:0] erd, input int lat,
                         output int t);
    exp_t e;
    @(negedge clk);
    inst_req = 1'b1; inst_addr = addr;
    t = cyc;
    e.who = 0; e.rd = erd; e.err = 1'b0; e.chk_rd = 1'b1; e.cyc = cyc + lat;
    exp_q.push_back(e);
    wait_acks(n_acks + 1, 30, "inst_op");
    inst_req = 1'b0;
  endtask

  function automatic exp_t mk(input int who, input logic [63:0] rd, input int c);
    exp_t e;
    e.who = who; e.rd = rd; e.err = 1'b0; e.chk_rd = (who != 2); e.cyc = c;
    return e;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    int t;
    int base;
    int mreq0;
    int k;
    reset = 1'b1;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_cmd = '0; data_addr = '0; data_size = '0; data_wrdata = '0;
    ext_req = 1'b0; ext_addr = '0; ext_wrdata = '0;
    inst_req_b = 1'b0; inst_addr_b = '0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_inst_ack", 64'(inst_ack), 64'd0);
    check("rst_data_ack", 64'(data_ack), 64'd0);
    check("rst_ext_ack", 64'(ext_ack), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wrmask", 64'(mem_wrmask), 64'd0);
    check("rst_mem_wrdata", mem_wrdata, 64'd0);
    check("rst_inst_rddata", 64'(inst_rddata), 64'd0);
    check("rst_data_rddata", data_rddata, 64'd0);
    check("rst_data_err", 64'(data_err), 64'd0);
    check("rst_lat3_ack", 64'(inst_ack_b), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // data read, half-word at byte 3 of word 2
    do_data(2'd0, 16'h0013, 3'd1, 64'h0, 64'h5544, 1'b0, 1'b1, 3, t);
    check("t1_mem_addr", 64'(last_addr), 64'd2);
    check("t1_mem_we", 64'(last_we), 64'd0);
    check("t1_issue_cycle", 64'(last_cyc), 64'(t + 1));

    // data write, half-word into the top lanes of word 0
    do_data(2'd1, 16'h0006, 3'd1, 64'hBEEF, 64'h0, 1'b0, 1'b0, 2, t);
    check("t2_mem_we", 64'(last_we), 64'd1);
    check("t2_mem_wrmask", 64'(last_mask), 64'hC0);
    check("t2_mem_wrdata", last_wd, 64'hBEEF_0000_0000_0000);
    check("t2_mem_addr", 64'(last_addr), 64'd0);
    check("t2_issue_cycle", 64'(last_cyc), 64'(t + 1));

    // read back the written word; only lanes 6,7 changed
    do_data(2'd0, 16'h0000, 3'd3, 64'h0, 64'hBEEF_0000_5500_0000, 1'b0, 1'b1, 3, t);
    // cmd 2 behaves as a read; single byte in lane 7
    do_data(2'd2, 16'h0017, 3'd0, 64'h0, 64'h88, 1'b0, 1'b1, 3, t);
    check("cmd2_mem_we", 64'(last_we), 64'd0);

    // instruction fetch, upper and lower halves
    do_inst(16'h0014, 64'h8877_6655, 3, t);
    check("inst_mem_addr", 64'(last_addr), 64'd2);
    do_inst(16'h0020, 64'h5500_0004, 3, t);

    // data/inst tie right after reset: data first, then alternating
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    data_req = 1'b1; data_cmd = 2'd0; data_addr = 16'h0008; data_size = 3'd2;
    inst_req = 1'b1; inst_addr = 16'h001C;
    t = cyc;
    exp_q.push_back(mk(1, 64'h5500_0001, t + 3));
    exp_q.push_back(mk(0, 64'hAA00_0003, t + 7));
    exp_q.push_back(mk(1, 64'h5500_0001, t + 11));
    exp_q.push_back(mk(0, 64'hAA00_0003, t + 15));
    wait_acks(n_acks + 4, 60, "rr_tie");
    data_req = 1'b0; inst_req = 1'b0;

    // ext held with data held: 8 ext writes, forced data read, ext resumes
    @(negedge clk);
    ext_req = 1'b1; ext_addr = 16'h0104; ext_wrdata = 32'h1234_5678;
    data_req = 1'b1; data_cmd = 2'd0; data_addr = 16'h0104; data_size = 3'd2;
    t = cyc;
    base = n_acks;
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(2, 64'h0, t + 2 + 3 * i));
    exp_q.push_back(mk(1, 64'h1234_5678, t + 27));
    exp_q.push_back(mk(2, 64'h0, t + 30));
    k = 0;
    while (n_acks < base + 10 && k < 100) begin
      @(negedge clk);
      #1;
      k++;
      if (data_ack) data_req = 1'b0;
    end
    check("starve_completed", 64'(n_acks >= base + 10), 64'd1);
    ext_req = 1'b0; data_req = 1'b0;
    // ext writes landed only in the upper half
    do_data(2'd0, 16'h0100, 3'd3, 64'h0, 64'h1234_5678_5500_0020, 1'b0, 1'b1, 3, t);

    // refused accesses: lane overflow, illegal size, overflowing write
    mreq0 = mreq_cnt;
    do_data(2'd0, 16'h0005, 3'd2, 64'h0, 64'h0, 1'b1, 1'b1, 1, t);
    do_data(2'd0, 16'h0000, 3'd4, 64'h0, 64'h0, 1'b1, 1'b1, 1, t);
    do_data(2'd1, 16'h0001, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b1, 1, t);
    check("err_no_mem_req", 64'(mreq_cnt), 64'(mreq0));

    // reset during WAIT of a latency-3 fetch
    @(negedge clk);
    inst_req_b = 1'b1; inst_addr_b = 16'h0014;
    @(negedge clk);
    #1;
    check("lat3_issue", 64'(mem_req_b), 64'd1);
    @(negedge clk);
    reset = 1'b1; inst_req_b = 1'b0;
    @(negedge clk);
    #1;
    check("lat3_rst_ack", 64'(inst_ack_b), 64'd0);
    check("lat3_rst_mem_req", 64'(mem_req_b), 64'd0);
    check("lat3_rst_mem_addr", 64'(mem_addr_b), 64'd0);
    check("lat3_rst_rddata", 64'(inst_rddata_b), 64'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("lat3_no_stale_ack", 64'(n_acks_b), 64'd0);
    @(negedge clk);
    inst_req_b = 1'b1; inst_addr_b = 16'h000C;
    exp_qb.push_back(mk(0, 64'hB0B0_0001, cyc + 5));
    k = 0;
    while (n_acks_b < 1 && k < 30) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("lat3_completed", 64'(n_acks_b), 64'd1);
    inst_req_b = 1'b0;

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("lat3_queue_drained", 64'(exp_qb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
